// File: rtl/nn_conv_sched.sv
// Convolution scheduler: one shared K*K multiply-add tree walks every output
// position and filter of a latched image, streaming results through a valid/ready register.

module nn_conv_tap #(
    parameter int PW = 2
) (
    input  logic [PW-1:0]   px,
    input  logic [PW-1:0]   wt,
    output logic [2*PW-1:0] prod
);
    assign prod = {{PW{1'b0}}, px} * {{PW{1'b0}}, wt};
endmodule

module nn_conv_sched #(
    parameter int IMG_W = 12,
    parameter int K     = 3,
    parameter int NFILT = 4,
    parameter int PW    = 2,
    localparam int OW   = IMG_W - K + 1,
    localparam int CW   = (OW > 1) ? $clog2(OW) : 1,
    localparam int FW   = (NFILT > 1) ? $clog2(NFILT) : 1,
    localparam int RW   = $clog2(K*K*(2**PW-1)*(2**PW-1) + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [IMG_W*IMG_W*PW-1:0]  img,
    input  logic [NFILT*K*K*PW-1:0]    filt,
    output logic                       busy,
    output logic                       done,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [RW-1:0]              res_data,
    output logic [FW-1:0]              res_filt,
    output logic [CW-1:0]              res_row,
    output logic [CW-1:0]              res_col
);
    localparam int IW  = $clog2(IMG_W*IMG_W*PW);
    localparam int WIW = $clog2(NFILT*K*K*PW);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;

    logic [IMG_W*IMG_W*PW-1:0] img_q;
    logic [NFILT*K*K*PW-1:0]   filt_q;
    logic [CW-1:0]             r, c;
    logic [FW-1:0]             f;
    logic                      issued_all;
    logic                      accept, load, fin, last_idx;
    logic [K*K-1:0][2*PW-1:0]  prod;
    logic [RW-1:0]             mac_sum;

    assign busy     = (state == RUN);
    assign last_idx = (r == CW'(OW-1)) && (c == CW'(OW-1)) && (f == FW'(NFILT-1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Output register refills whenever it is empty or being drained this edge.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        load     = 1'b0;
        fin      = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept   = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                fin  = res_valid && res_ready && issued_all;
                load = !issued_all && (!res_valid || res_ready);
                if (fin) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            img_q  <= img;
            filt_q <= filt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done       <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_filt   <= '0;
            res_row    <= '0;
            res_col    <= '0;
            r          <= '0;
            c          <= '0;
            f          <= '0;
            issued_all <= 1'b0;
        end else begin
            done <= fin;
            if (accept) begin
                r          <= '0;
                c          <= '0;
                f          <= '0;
                issued_all <= 1'b0;
            end
            if (load) begin
                res_valid <= 1'b1;
                res_data  <= mac_sum;
                res_filt  <= f;
                res_row   <= r;
                res_col   <= c;
                if (last_idx) issued_all <= 1'b1;
                if (f == FW'(NFILT-1)) begin
                    f <= '0;
                    if (c == CW'(OW-1)) begin
                        c <= '0;
                        r <= r + 1'b1;
                    end else begin
                        c <= c + 1'b1;
                    end
                end else begin
                    f <= f + 1'b1;
                end
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    for (genvar t = 0; t < K*K; t++) begin : g_tap
        localparam int TI = t / K;
        localparam int TJ = t % K;
        logic [IW-1:0]  pidx;
        logic [WIW-1:0] widx;
        assign pidx = IW'(PW*((int'(r) + TI)*IMG_W + int'(c) + TJ));
        assign widx = WIW'(K*K*PW*int'(f) + PW*t);
        nn_conv_tap #(.PW(PW)) u_tap (
            .px   (img_q[pidx +: PW]),
            .wt   (filt_q[widx +: PW]),
            .prod (prod[t])
        );
    end

    always_comb begin
        mac_sum = '0;
        for (int t = 0; t < K*K; t++) mac_sum = mac_sum + RW'(prod[t]);
    end
endmodule

// File: doc/nn_conv_sched.md
NN_CONV_SCHED -- requirements
Module: nn_conv_sched

Interface
REQ-001 SHALL provide parameter IMG_W, default 12, input image width and height in pixels (square image).
REQ-002 SHALL provide parameter K, default 3, convolution kernel width and height.
REQ-003 SHALL provide parameter NFILT, default 4, number of filters sharing one MAC datapath.
REQ-004 SHALL provide parameter PW, default 2, bit width of each pixel and each weight (unsigned).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  request to begin one full convolution pass.
REQ-008 SHALL have port img  input  IMG_W*IMG_W*PW (288)  image; pixel (r,c) at bits [PW*(r*IMG_W+c) +: PW].
REQ-009 SHALL have port filt  input  NFILT*K*K*PW (72)  weights; filter f tap (i,j) at bits [K*K*PW*f + PW*(i*K+j) +: PW].
REQ-010 SHALL have port busy  output  1  pass in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the final result handshake.
REQ-012 SHALL have port res_valid  output  1  result register holds a valid result.
REQ-013 SHALL have port res_ready  input  1  downstream accepts the result.
REQ-014 SHALL have port res_data  output  7  convolution sum (width ceil(log2(K*K*(2^PW-1)^2+1)) = 7 at defaults).
REQ-015 SHALL have port res_filt  output  2  filter index of res_data.
REQ-016 SHALL have port res_row, res_col  output  4 each  output-map coordinates of res_data.

Function
REQ-017 SHALL implement FSM states IDLE and RUN; at most one pass is in flight.
REQ-018 In IDLE, on an edge with start=1, SHALL latch img and filt into internal registers, clear the index counters, and enter RUN; busy=1 from that edge.
REQ-019 SHALL ignore start while in RUN; input changes after latching SHALL NOT affect results.
REQ-020 Output map SHALL be (IMG_W-K+1)^2 positions (10x10) times NFILT filters = 400 results per pass.
REQ-021 res(r,c,f) SHALL equal the sum over i,j in 0..K-1 of pixel(r+i,c+j)*weight_f(i,j), unsigned, exact with no truncation (max 81).
REQ-022 Issue order SHALL be row-major, with f innermost, then c, then r: (0,0,0),(0,0,1),...,(0,0,3),(0,1,0),...,(9,9,3).
REQ-023 Latency: the first result SHALL load into the output register on the edge after the start-accept edge, with res_valid=1.
REQ-024 On each edge with res_valid=1 and res_ready=1, the next result SHALL load with no bubble; throughput is one result per cycle.
REQ-025 While res_valid=1 and res_ready=0, res_data, res_filt, res_row and res_col SHALL hold stable.
REQ-026 On the handshake of (9,9,3): res_valid->0, busy->0, done->1 for exactly one cycle, state->IDLE.
REQ-027 A start asserted in the same cycle as done=1 SHALL be accepted, because the FSM is already in IDLE.
REQ-028 The MAC SHALL be a single shared K*K multiply-add tree; filters are time-multiplexed, not replicated.
REQ-029 Counter wrap: f wraps 3->0 and increments c; c wraps 9->0 and increments r; r=9,c=9,f=3 is the terminal index.

Reset
REQ-030 rst=1 SHALL force, on the same edge: state=IDLE, busy=0, done=0, res_valid=0, res_data=0, res_filt=0, res_row=0, res_col=0, all counters 0.
REQ-031 rst=1 mid-pass SHALL abort the pass; no further results appear until a new start.
REQ-032 start SHALL be ignored on any edge where rst=1.
REQ-033 The latched operand registers need not be reset.

Verification
REQ-034 Center-tap identity: filter0 tap(1,1)=1, other taps 0; res_ready=1 -> every f=0 result equals pixel(r+1,c+1); f=1..3 results, with all-zero weights, equal 0.
REQ-035 Saturation corner: all pixels=3, all weights=3 -> all 400 results = 81; no wrap.
REQ-036 Backpressure: res_ready random at 50% -> outputs stable while stalled; exactly 400 results received in REQ-022 order, each matching a reference model.
REQ-037 Timing: res_ready=1, start accepted at edge E0 -> first res_valid after E1, done=1 after E401 only, busy=0 after E401.
REQ-038 Reset mid-run: rst pulsed after 57 handshakes -> res_valid=0, busy=0 next cycle; a new start yields (0,0,0) first.
REQ-039 Start while busy, with img/filt altered mid-pass -> ignored; results reflect the originally latched operands; done pulses once.
